// File: rtl/mtr_pwm_drv.sv
// Dual H-bridge PWM driver: turns signed per-wheel speed commands into complementary
// fwd/rev PWM lines with a fixed 2**PWM_W period and dead time on direction reversals.
module mtr_pwm_drv #(
    parameter int PWM_W    = 11,
    parameter int DEAD_CYC = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [11:0] lft_spd,
    input  logic [11:0] rght_spd,
    output logic        lft_fwd_pwm,
    output logic        lft_rev_pwm,
    output logic        rght_fwd_pwm,
    output logic        rght_rev_pwm,
    output logic        prd_strt
);

    localparam int                 SPD_W       = 12;
    localparam logic [PWM_W-1:0]   CNT_MAX     = '1;
    localparam logic [PWM_W-1:0]   DEAD_LAST   = PWM_W'(DEAD_CYC - 1);
    localparam logic [SPD_W:0]     ONE_EXT     = (SPD_W + 1)'(1);
    localparam logic [SPD_W:0]     MAG_MAX_EXT = (SPD_W + 1)'(CNT_MAX);

    typedef enum logic [1:0] {
        COAST,
        FWD,
        REV,
        DEAD
    } side_state_t;

    logic [PWM_W-1:0] cnt;
    logic             latch;
    logic             rst_q;

    logic [SPD_W-1:0] spd     [2];
    logic [PWM_W-1:0] new_mag [2];
    logic             new_dir [2];

    side_state_t      state_q [2];
    side_state_t      state_d [2];
    logic [PWM_W-1:0] mag_q   [2];
    logic [PWM_W-1:0] mag_d   [2];
    logic             dir_q   [2];
    logic             dir_d   [2];
    logic             fwd_q   [2];
    logic             fwd_d   [2];
    logic             rev_q   [2];
    logic             rev_d   [2];

    // Magnitude of a two's complement command; the most negative value saturates to full scale.
    function automatic logic [PWM_W-1:0] sat_mag(input logic [SPD_W-1:0] s);
        logic [SPD_W:0] ext;
        logic [SPD_W:0] abs_v;
        ext   = {s[SPD_W-1], s};
        abs_v = s[SPD_W-1] ? (~ext + ONE_EXT) : ext;
        if (abs_v > MAG_MAX_EXT) begin
            return CNT_MAX;
        end
        return abs_v[PWM_W-1:0];
    endfunction

    assign latch  = (cnt == CNT_MAX);
    assign spd[0] = lft_spd;
    assign spd[1] = rght_spd;

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            new_mag[s] = sat_mag(spd[s]);
            new_dir[s] = spd[s][SPD_W-1];
        end
    end

    // Side FSMs only move at the latch, except DEAD which releases DEAD_CYC clocks into the period.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            state_d[s] = state_q[s];
            mag_d[s]   = mag_q[s];
            dir_d[s]   = dir_q[s];
            fwd_d[s]   = 1'b0;
            rev_d[s]   = 1'b0;
            if (!en) begin
                state_d[s] = COAST;
                mag_d[s]   = '0;
            end else begin
                if (latch) begin
                    mag_d[s] = new_mag[s];
                    if (new_mag[s] == '0) begin
                        state_d[s] = COAST;
                    end else begin
                        dir_d[s] = new_dir[s];
                        case (state_q[s])
                            FWD:     state_d[s] = new_dir[s] ? DEAD : FWD;
                            REV:     state_d[s] = new_dir[s] ? REV : DEAD;
                            default: state_d[s] = new_dir[s] ? REV : FWD;
                        endcase
                    end
                end else if ((state_q[s] == DEAD) && (cnt == DEAD_LAST)) begin
                    state_d[s] = dir_q[s] ? REV : FWD;
                end
                fwd_d[s] = (state_q[s] == FWD) && (cnt < mag_q[s]);
                rev_d[s] = (state_q[s] == REV) && (cnt < mag_q[s]);
            end
        end
    end

    // rst_q marks the first cycle out of reset so the restarted period is announced on prd_strt.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            rst_q    <= 1'b1;
            prd_strt <= 1'b0;
            for (int s = 0; s < 2; s++) begin
                state_q[s] <= COAST;
                mag_q[s]   <= '0;
                dir_q[s]   <= 1'b0;
                fwd_q[s]   <= 1'b0;
                rev_q[s]   <= 1'b0;
            end
        end else begin
            cnt      <= cnt + PWM_W'(1);
            rst_q    <= 1'b0;
            prd_strt <= latch | rst_q;
            for (int s = 0; s < 2; s++) begin
                state_q[s] <= state_d[s];
                mag_q[s]   <= mag_d[s];
                dir_q[s]   <= dir_d[s];
                fwd_q[s]   <= fwd_d[s];
                rev_q[s]   <= rev_d[s];
            end
        end
    end

    assign lft_fwd_pwm  = fwd_q[0];
    assign lft_rev_pwm  = rev_q[0];
    assign rght_fwd_pwm = fwd_q[1];
    assign rght_rev_pwm = rev_q[1];

endmodule

// File: tb/tb_mtr_pwm_drv.sv
// Testbench for mtr_pwm_drv: per-period pulse-width vectors, directed reversal/enable/reset
// sequences, and a randomized run checked every cycle against a period-plan reference model.
module tb_mtr_pwm_drv;

    localparam int PERIOD = 2048;
    localparam int DEAD   = 32;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic        en       = 1'b0;
    logic [11:0] lft_spd  = 12'd0;
    logic [11:0] rght_spd = 12'd0;
    logic        lft_fwd_pwm;
    logic        lft_rev_pwm;
    logic        rght_fwd_pwm;
    logic        rght_rev_pwm;
    logic        prd_strt;
    logic [4:0]  dut_vec;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mtr_pwm_drv #(
        .PWM_W    (11),
        .DEAD_CYC (DEAD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .lft_spd      (lft_spd),
        .rght_spd     (rght_spd),
        .lft_fwd_pwm  (lft_fwd_pwm),
        .lft_rev_pwm  (lft_rev_pwm),
        .rght_fwd_pwm (rght_fwd_pwm),
        .rght_rev_pwm (rght_rev_pwm),
        .prd_strt     (prd_strt)
    );

    assign dut_vec = {lft_fwd_pwm, lft_rev_pwm, rght_fwd_pwm, rght_rev_pwm, prd_strt};

    // Reference model: each latch produces a plan per side (line, pulse width, first active count).
    int          phase     = 0;
    int          line  [2] = '{0, 0};
    int          mmag  [2] = '{0, 0};
    int          mstart[2] = '{0, 0};
    int          want;
    int          m;
    bit          rstq      = 1'b0;
    bit          model_ok  = 1'b0;
    bit          efwd  [2];
    bit          erev  [2];
    logic [11:0] sp    [2];
    logic [4:0]  exp_vec   = 5'd0;

    function automatic int mag_of(input logic [11:0] s);
        int v;
        v = $signed(s);
        if (v < 0) v = -v;
        if (v > PERIOD - 1) v = PERIOD - 1;
        return v;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            phase    = 0;
            line     = '{0, 0};
            mmag     = '{0, 0};
            mstart   = '{0, 0};
            rstq     = 1'b1;
            exp_vec  = 5'd0;
            model_ok = 1'b1;
        end else begin
            sp[0] = lft_spd;
            sp[1] = rght_spd;
            for (int s = 0; s < 2; s++) begin
                efwd[s] = en && (line[s] == 1) && (phase >= mstart[s]) && (phase < mmag[s]);
                erev[s] = en && (line[s] == 2) && (phase >= mstart[s]) && (phase < mmag[s]);
            end
            exp_vec = {efwd[0], erev[0], efwd[1], erev[1], (phase == PERIOD - 1) || rstq};
            rstq    = 1'b0;
            if (!en) begin
                line = '{0, 0};
                mmag = '{0, 0};
                mstart = '{0, 0};
            end else if (phase == PERIOD - 1) begin
                for (int s = 0; s < 2; s++) begin
                    m = mag_of(sp[s]);
                    if (m == 0) begin
                        line[s]   = 0;
                        mmag[s]   = 0;
                        mstart[s] = 0;
                    end else begin
                        want      = sp[s][11] ? 2 : 1;
                        mstart[s] = (line[s] != 0 && line[s] != want) ? DEAD : 0;
                        line[s]   = want;
                        mmag[s]   = m;
                    end
                end
            end
            phase = (phase + 1) % PERIOD;
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++;
                $display("[TB] FAIL model_cycle t=%0t phase=%0d actual=%b required=%b", $time, phase, dut_vec, exp_vec);
            end
            checks++;
            assert (!((lft_fwd_pwm && lft_rev_pwm) || (rght_fwd_pwm && rght_rev_pwm))) else begin
                errors++;
                $display("[TB] FAIL fwd_rev_overlap t=%0t actual=%b required=no side with both lines high", $time, dut_vec);
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, required);
        end
    endtask

    task automatic applyStimulus(input logic [11:0] l, input logic [11:0] r);
        lft_spd  = l;
        rght_spd = r;
    endtask

    task automatic wait_prd();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (prd_strt !== 1'b1 && n < PERIOD + 50);
        if (prd_strt !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL prd_strt_timeout actual=no pulse in %0d cycles required=pulse", n);
        end
    endtask

    // Counts high cycles of every line over one whole period, starting at its prd_strt cycle.
    task automatic measure_period(output int lf, output int lr, output int rf, output int rr,
                                  output int first_lf, output int first_lr);
        wait_prd();
        lf = 0; lr = 0; rf = 0; rr = 0;
        first_lf = -1;
        first_lr = -1;
        for (int i = 0; i < PERIOD; i++) begin
            if (i > 0) @(negedge clk);
            lf += int'(lft_fwd_pwm);
            lr += int'(lft_rev_pwm);
            rf += int'(rght_fwd_pwm);
            rr += int'(rght_rev_pwm);
            if (lft_fwd_pwm === 1'b1 && first_lf < 0) first_lf = i;
            if (lft_rev_pwm === 1'b1 && first_lr < 0) first_lr = i;
        end
    endtask

    typedef struct {
        logic [11:0] l_spd;
        logic [11:0] r_spd;
        int          lf;
        int          lr;
        int          rf;
        int          rr;
    } vec_t;

    initial begin
        vec_t tbl [7];
        int   lf, lr, rf, rr, flf, flr, acc, hold, sel;
        logic [11:0] rl, rr_spd;

        tbl[0] = '{12'd500,  12'd0,    500,  0,    0,    0};
        tbl[1] = '{12'd0,    12'd0,    0,    0,    0,    0};
        tbl[2] = '{12'hED4,  12'h7FF,  0,    300,  2047, 0};
        tbl[3] = '{12'hED4,  12'h800,  0,    300,  0,    2047};
        tbl[4] = '{12'd1,    12'hFFF,  1,    0,    0,    1};
        tbl[5] = '{12'h7FF,  12'd0,    2047, 0,    0,    0};
        tbl[6] = '{12'h801,  12'd100,  0,    2047, 100,  0};

        repeat (3) @(negedge clk);
        checkOutput("reset_outputs", int'(dut_vec), 0);
        rst = 1'b0;
        en  = 1'b1;

        for (int i = 0; i < 7; i++) begin
            applyStimulus(tbl[i].l_spd, tbl[i].r_spd);
            wait_prd();
            measure_period(lf, lr, rf, rr, flf, flr);
            checkOutput($sformatf("vec%0d_lft_fwd_width", i), lf, tbl[i].lf);
            checkOutput($sformatf("vec%0d_lft_rev_width", i), lr, tbl[i].lr);
            checkOutput($sformatf("vec%0d_rght_fwd_width", i), rf, tbl[i].rf);
            checkOutput($sformatf("vec%0d_rght_rev_width", i), rr, tbl[i].rr);
        end

        // Coast to forward, then a mid-period reversal and its dead-time period.
        applyStimulus(12'd0, 12'd0);
        wait_prd();
        applyStimulus(12'd500, 12'd0);
        measure_period(lf, lr, rf, rr, flf, flr);
        checkOutput("coast_fwd_width", lf, 500);
        checkOutput("coast_fwd_first_high", flf, 1);
        checkOutput("coast_fwd_rev_width", lr, 0);
        wait_prd();
        repeat (1000) @(negedge clk);
        applyStimulus(12'hE0C, 12'd0);
        measure_period(lf, lr, rf, rr, flf, flr);
        checkOutput("reversal_fwd_width", lf, 0);
        checkOutput("reversal_rev_width", lr, 500 - DEAD);
        checkOutput("reversal_rev_first_high", flr, DEAD + 1);
        measure_period(lf, lr, rf, rr, flf, flr);
        checkOutput("post_reversal_rev_width", lr, 500);
        checkOutput("post_reversal_rev_first_high", flr, 1);
        applyStimulus(12'd0, 12'd0);
        wait_prd();
        applyStimulus(12'hED4, 12'd0);
        measure_period(lf, lr, rf, rr, flf, flr);
        checkOutput("coast_rev_width", lr, 300);
        checkOutput("coast_rev_first_high", flr, 1);
        checkOutput("coast_rev_fwd_width", lf, 0);

        // Enable drop at cnt=100; drive only resumes at the next latch, without dead time.
        applyStimulus(12'd1000, 12'd0);
        wait_prd();
        wait_prd();
        repeat (100) @(negedge clk);
        checkOutput("en_pre_drop_lft_fwd", int'(lft_fwd_pwm), 1);
        en = 1'b0;
        @(negedge clk);
        checkOutput("en_drop_next_cycle", int'(lft_fwd_pwm | lft_rev_pwm), 0);
        applyStimulus(12'hC18, 12'd0);
        repeat (199) @(negedge clk);
        en  = 1'b1;
        acc = 0;
        for (int i = 300; i < PERIOD - 1; i++) begin
            @(negedge clk);
            acc += int'(lft_fwd_pwm) + int'(lft_rev_pwm);
        end
        checkOutput("en_resume_waits_for_latch", acc, 0);
        measure_period(lf, lr, rf, rr, flf, flr);
        checkOutput("en_resume_rev_width", lr, 1000);
        checkOutput("en_resume_rev_first_high", flr, 1);
        checkOutput("en_resume_fwd_width", lf, 0);

        // One-cycle reset at cnt=1500 while both sides drive.
        applyStimulus(12'h7D0, 12'hD44);
        wait_prd();
        wait_prd();
        repeat (1500) @(negedge clk);
        checkOutput("rst_pre_lft_fwd", int'(lft_fwd_pwm), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_outputs_cleared", int'(dut_vec), 0);
        @(negedge clk);
        checkOutput("rst_prd_after_release", int'(prd_strt), 1);
        measure_period(lf, lr, rf, rr, flf, flr);
        checkOutput("rst_resume_lft_fwd_width", lf, 2000);
        checkOutput("rst_resume_lft_fwd_first_high", flf, 1);
        checkOutput("rst_resume_rght_rev_width", rr, 700);

        // Randomized commands, enable drops and resets, checked cycle by cycle by the model.
        for (int it = 0; it < 10; it++) begin
            sel = $urandom_range(0, 5);
            rl  = 12'($urandom);
            case (sel)
                0:       rr_spd = 12'h000;
                1:       rr_spd = 12'h800;
                2:       rr_spd = 12'h7FF;
                default: rr_spd = 12'($urandom);
            endcase
            applyStimulus(rl, rr_spd);
            en = ($urandom_range(0, 5) != 0);
            if ($urandom_range(0, 7) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            hold = $urandom_range(50, 1800);
            repeat (hold) @(negedge clk);
        end
        en = 1'b1;
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
